// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows stage with two ping-pong 16-byte banks.
// One bank fills while the other drains, so the stream can sustain one byte per cycle.
module inv_shift_rows_stream (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic [3:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_st_e;

  bank_st_e   st_q [2];
  logic       wr_bank_q;
  logic [3:0] wr_cnt_q;
  logic [3:0] wr_cnt_d;
  logic       rd_bank_q;
  logic [3:0] rd_cnt_q;
  logic [3:0] rd_cnt_d;
  logic [7:0] mem_q [2][16];

  logic       wr_fire;
  logic       rd_fire;
  logic [1:0] src_col;
  logic [3:0] src_idx;

  // Handshake: a byte moves on a side exactly in a cycle where valid && ready
  // are both high at the rising edge; flush in that cycle cancels the transfer.
  assign s_ready = (st_q[wr_bank_q] == ST_EMPTY) || (st_q[wr_bank_q] == ST_FILLING);
  assign m_valid = (st_q[rd_bank_q] == ST_FULL)  || (st_q[rd_bank_q] == ST_DRAINING);
  assign m_last  = m_valid && (rd_cnt_q == 4'd15);

  assign wr_fire  = s_valid && s_ready && !flush;
  assign rd_fire  = m_valid && m_ready && !flush;
  assign wr_cnt_d = wr_cnt_q + 4'd1;
  assign rd_cnt_d = rd_cnt_q + 4'd1;

  // Output byte 4c+r comes from column (c-r) mod 4 of the same row.
  assign src_col = rd_cnt_q[3:2] - rd_cnt_q[1:0];
  assign src_idx = {src_col, rd_cnt_q[1:0]};
  assign m_data  = m_valid ? mem_q[rd_bank_q][src_idx] : 8'h00;

  assign dbg_state = {st_q[1], st_q[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]   <= ST_EMPTY;
      st_q[1]   <= ST_EMPTY;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= 4'd0;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= 4'd0;
    end else if (flush) begin
      st_q[0]   <= ST_EMPTY;
      st_q[1]   <= ST_EMPTY;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= 4'd0;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= 4'd0;
    end else begin
      // Writer and reader never share a bank: the writer owns EMPTY/FILLING
      // banks, the reader owns FULL/DRAINING ones.
      if (wr_fire) begin
        wr_cnt_q <= wr_cnt_d;
        if (wr_cnt_q == 4'd15) begin
          st_q[wr_bank_q] <= ST_FULL;
          wr_bank_q       <= ~wr_bank_q;
        end else begin
          st_q[wr_bank_q] <= ST_FILLING;
        end
      end
      if (rd_fire) begin
        rd_cnt_q <= rd_cnt_d;
        if (rd_cnt_q == 4'd15) begin
          st_q[rd_bank_q] <= ST_EMPTY;
          rd_bank_q       <= ~rd_bank_q;
        end else begin
          st_q[rd_bank_q] <= ST_DRAINING;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_cnt_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Bench for inv_shift_rows_stream: random and directed byte streams checked
// against a block-level InvShiftRows model and an expected-byte queue.
module tb_inv_shift_rows_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       m_ready = 1'b0;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic [3:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       got_last_q[$];

  bit         cyc_sent;
  bit         cyc_took;
  bit         obs_s_ready;
  bit         obs_m_valid;
  logic [7:0] obs_m_data;

  logic [7:0] golden [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                              8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};

  inv_shift_rows_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Out byte at column c, row r takes the input byte from column (c - r) mod 4.
  function automatic void push_expected(input logic [7:0] blk [16]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        exp_q.push_back(blk[4 * ((c - r + 4) % 4) + r]);
      end
    end
  endfunction

  task automatic add_block(input logic [7:0] blk [16]);
    for (int i = 0; i < 16; i++) in_q.push_back(blk[i]);
    push_expected(blk);
  endtask

  task automatic add_random_block();
    logic [7:0] blk [16];
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(0, 255));
    add_block(blk);
  endtask

  task automatic clear_queues();
    in_q.delete();
    exp_q.delete();
    got_q.delete();
    got_last_q.delete();
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; applies inputs, records what transfers at the
  // next rising edge, and returns at the following falling edge.
  task automatic drive_cycle(input bit send_en, input bit take_en, input bit do_flush);
    s_valid = send_en && (in_q.size() > 0);
    if (s_valid) s_data = in_q[0];
    else         s_data = 8'h00;
    m_ready = take_en;
    flush   = do_flush;
    #1;
    obs_s_ready = s_ready;
    obs_m_valid = m_valid;
    obs_m_data  = m_data;
    cyc_sent = s_valid && s_ready && !do_flush;
    cyc_took = m_valid && m_ready && !do_flush;
    if (cyc_took) begin
      got_q.push_back(m_data);
      got_last_q.push_back(m_last);
    end
    if (cyc_sent) void'(in_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic run_until(input int n_out, input int take_pct, output bit timed_out);
    int cyc = 0;
    while (got_q.size() < n_out && cyc < 400) begin
      drive_cycle(1'b1, ($urandom_range(0, 99) < take_pct), 1'b0);
      cyc++;
    end
    timed_out = (got_q.size() < n_out);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h want 00", m_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_s_ready: got %b want 1", s_ready); end
    @(negedge clk);
  endtask

  task automatic test_single_block();
    int  cyc = 0;
    bit  early = 0;
    bit  to;
    clear_queues();
    for (int i = 0; i < 16; i++) in_q.push_back(8'(i));
    while (in_q.size() > 0 && cyc < 100) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      if (obs_m_valid) early = 1;
      cyc++;
    end
    checks++; if (early) begin errors++; $display("FAIL single_early_valid: got m_valid=1 before block complete, want 0"); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got m_valid=%b after 16th byte, want 1", m_valid); end
    run_until(16, 100, to);
    checks++; if (to) begin errors++; $display("FAIL single_timeout: got %0d bytes want 16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      checks++;
      if (got_q[i] !== golden[i] || got_last_q[i] !== (i == 15)) begin
        errors++;
        $display("FAIL single_byte[%0d]: got %h last=%b want %h last=%b", i, got_q[i], got_last_q[i], golden[i], (i == 15));
      end
    end
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL single_idle: got m_valid=%b s_ready=%b want 0 1", m_valid, s_ready); end
  endtask

  task automatic test_fips();
    logic [127:0] st;
    logic [7:0]   blk [16];
    bit           to;
    st = 128'h7a9f102789d5f50b2beffd9f3dca4ce7;
    drive_cycle(1'b0, 1'b0, 1'b1);
    clear_queues();
    for (int i = 0; i < 16; i++) blk[i] = st[8*i +: 8];
    add_block(blk);
    run_until(16, 60, to);
    checks++; if (to) begin errors++; $display("FAIL fips_timeout: got %0d bytes want 16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 15)) begin
        errors++;
        $display("FAIL fips_byte[%0d]: got %h last=%b want %h last=%b", i, got_q[i], got_last_q[i], exp_q[i], (i == 15));
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int first_take = -1;
    int bubbles = 0;
    int stalls = 0;
    drive_cycle(1'b0, 1'b0, 1'b1);
    clear_queues();
    repeat (4) add_random_block();
    while (got_q.size() < 64 && cyc < 300) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      if (s_valid && !obs_s_ready) stalls++;
      if (first_take >= 0 && !cyc_took) bubbles++;
      if (cyc_took && first_take < 0) first_take = cyc;
      cyc++;
    end
    checks++; if (got_q.size() != 64) begin errors++; $display("FAIL b2b_count: got %0d bytes want 64", got_q.size()); end
    checks++; if (first_take != 16) begin errors++; $display("FAIL b2b_first_out: got cycle %0d want 16", first_take); end
    checks++; if (bubbles != 0) begin errors++; $display("FAIL b2b_bubbles: got %0d want 0", bubbles); end
    checks++; if (stalls != 0) begin errors++; $display("FAIL b2b_s_ready_drop: got %0d stalled cycles want 0", stalls); end
    for (int i = 0; i < got_q.size() && i < 64; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== ((i % 16) == 15)) begin
        errors++;
        $display("FAIL b2b_byte[%0d]: got %h last=%b want %h last=%b", i, got_q[i], got_last_q[i], exp_q[i], ((i % 16) == 15));
      end
    end
  endtask

  task automatic test_backpressure();
    int         sent = 0;
    int         cyc = 0;
    int         unstable = 0;
    bit         hold;
    logic [7:0] held;
    drive_cycle(1'b0, 1'b0, 1'b1);
    clear_queues();
    add_random_block();
    add_random_block();
    in_q.push_back(8'hA5);
    repeat (40) begin
      drive_cycle(1'b1, 1'b0, 1'b0);
      if (cyc_sent) sent++;
    end
    checks++; if (sent != 32) begin errors++; $display("FAIL bp_accepted: got %0d want 32", sent); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready: got %b want 0", s_ready); end
    in_q.delete();
    hold = 0;
    held = 8'h00;
    while (got_q.size() < 32 && cyc < 400) begin
      drive_cycle(1'b0, ($urandom_range(0, 99) < 40), 1'b0);
      if (hold && obs_m_valid && obs_m_data !== held) unstable++;
      hold = obs_m_valid && !m_ready;
      held = obs_m_data;
      cyc++;
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes while stalled want 0", unstable); end
    checks++; if (got_q.size() != 32) begin errors++; $display("FAIL bp_count: got %0d bytes want 32", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 32; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== ((i % 16) == 15)) begin
        errors++;
        $display("FAIL bp_byte[%0d]: got %h last=%b want %h last=%b", i, got_q[i], got_last_q[i], exp_q[i], ((i % 16) == 15));
      end
    end
  endtask

  task automatic test_flush_fill();
    bit to;
    drive_cycle(1'b0, 1'b0, 1'b1);
    clear_queues();
    for (int i = 0; i < 10; i++) in_q.push_back(8'($urandom_range(0, 255)));
    repeat (7) drive_cycle(1'b1, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b1);
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL flush_fill_state: got m_valid=%b s_ready=%b want 0 1", m_valid, s_ready); end
    clear_queues();
    for (int i = 0; i < 16; i++) in_q.push_back(8'(i));
    run_until(16, 100, to);
    checks++; if (to) begin errors++; $display("FAIL flush_fill_timeout: got %0d bytes want 16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      checks++;
      if (got_q[i] !== golden[i] || got_last_q[i] !== (i == 15)) begin
        errors++;
        $display("FAIL flush_fill_byte[%0d]: got %h last=%b want %h last=%b", i, got_q[i], got_last_q[i], golden[i], (i == 15));
      end
    end
  endtask

  task automatic test_flush_drain();
    bit to;
    drive_cycle(1'b0, 1'b0, 1'b1);
    clear_queues();
    add_random_block();
    for (int i = 0; i < 8; i++) in_q.push_back(8'($urandom_range(0, 255)));
    repeat (16) drive_cycle(1'b1, 1'b0, 1'b0);
    repeat (5) drive_cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (got_q.size() != 5 || got_q[0] !== exp_q[0] || got_q[4] !== exp_q[4]) begin
      errors++;
      $display("FAIL flush_drain_pre: got %0d bytes want 5 matching the model", got_q.size());
    end
    drive_cycle(1'b1, 1'b1, 1'b1);
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL flush_drain_state: got m_valid=%b s_ready=%b want 0 1", m_valid, s_ready); end
    clear_queues();
    for (int i = 0; i < 16; i++) in_q.push_back(8'(i));
    run_until(16, 100, to);
    checks++; if (to) begin errors++; $display("FAIL flush_drain_timeout: got %0d bytes want 16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      checks++;
      if (got_q[i] !== golden[i] || got_last_q[i] !== (i == 15)) begin
        errors++;
        $display("FAIL flush_drain_byte[%0d]: got %h last=%b want %h last=%b", i, got_q[i], got_last_q[i], golden[i], (i == 15));
      end
    end
  endtask

  task automatic test_async_reset();
    bit to;
    drive_cycle(1'b0, 1'b0, 1'b1);
    clear_queues();
    add_random_block();
    for (int i = 0; i < 4; i++) in_q.push_back(8'($urandom_range(0, 255)));
    repeat (20) drive_cycle(1'b1, 1'b0, 1'b0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b want 1", m_valid); end
    s_valid = 1'b0;
    m_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL areset_outputs: got s_ready=%b m_valid=%b m_last=%b m_data=%h want 1 0 0 00", s_ready, m_valid, m_last, m_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL areset_release: got s_ready=%b m_valid=%b want 1 0", s_ready, m_valid); end
    @(negedge clk);
    clear_queues();
    for (int i = 0; i < 16; i++) in_q.push_back(8'(i));
    run_until(16, 100, to);
    checks++; if (to) begin errors++; $display("FAIL areset_timeout: got %0d bytes want 16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      checks++;
      if (got_q[i] !== golden[i] || got_last_q[i] !== (i == 15)) begin
        errors++;
        $display("FAIL areset_byte[%0d]: got %h last=%b want %h last=%b", i, got_q[i], got_last_q[i], golden[i], (i == 15));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_block();
    test_fips();
    test_back_to_back();
    test_backpressure();
    test_flush_fill();
    test_flush_drain();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_shift_rows_stream.md
# inv_shift_rows_stream

Byte-serial AES InvShiftRows engine for the decryption datapath, the inverse-direction counterpart of the encryption ShiftRows stage. It accepts a 128-bit AES state as a stream of 16 bytes and emits the same 16 bytes in InvShiftRows order. Handshakes are valid/ready on both sides. Two 128-bit ping-pong banks allow one block to fill while the previous block drains, sustaining one byte per cycle. It sits between the byte-serial key-addition/InvMixColumns stage and the InvSubBytes stage of the iterative decryptor.

## Interface
- No parameters; block size is fixed at 16 bytes of 8 bits.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous abort; discards all buffered bytes.
- s_valid  input  1  input byte valid.
- s_ready  output  1  block can accept an input byte this cycle.
- s_data  input  8  input byte, state byte order (see Operation).
- m_valid  output  1  output byte valid.
- m_ready  input  1  downstream accepts the output byte.
- m_data  output  8  output byte, InvShiftRows order.
- m_last  output  1  high with the 16th byte of each output block.

## Operation
- Byte index i = 4c + r, where c is the column and r is the row (0..3). Byte 0 is the first byte on the stream. This matches the 128-bit state packing, where byte i = state[8i +: 8].
- InvShiftRows: out[4c+r] = in[4((c−r) mod 4) + r]. Row r rotates right by r.
- Storage:
  - Two banks B0 and B1, each 16×8 bits.
  - Per-bank status is one of EMPTY, FILLING, FULL, DRAINING.
  - Pointers: wr_bank (1 b), wr_cnt (4 b), rd_bank (1 b), rd_cnt (4 b).
- Write side:
  - s_ready = 1 iff bank[wr_bank] is EMPTY or FILLING.
  - On s_valid && s_ready, store s_data at bank[wr_bank][wr_cnt] and increment wr_cnt. Status becomes FILLING.
  - When the byte with wr_cnt = 15 is accepted: status becomes FULL, wr_cnt wraps to 0, and wr_bank toggles.
- Read side:
  - m_valid = 1 iff bank[rd_bank] is FULL or DRAINING.
  - m_data = bank[rd_bank][perm(rd_cnt)], where perm(k) = 4(((k>>2) − (k&3)) & 3) + (k&3). This is a combinational mux from registered storage.
  - m_last = m_valid && rd_cnt == 15.
  - On m_valid && m_ready, increment rd_cnt. Status becomes DRAINING.
  - When the byte with rd_cnt = 15 is accepted: status becomes EMPTY, rd_cnt wraps to 0, and rd_bank toggles.
- Bank state transitions:
  - EMPTY→FILLING on the first accepted byte.
  - FILLING→FULL on the 16th accepted byte.
  - FULL→DRAINING on the first output byte accepted.
  - DRAINING→EMPTY on the 16th output byte accepted.
  - EMPTY→FULL is impossible.
- Simultaneous events:
  - A write to one bank and a read from the other in the same cycle are both performed.
  - The write pointer and read pointer never target the same bank unless that bank is EMPTY (write) or FULL/DRAINING (read), so no same-bank collision occurs.
  - When the last output byte of bank X is accepted in the same cycle bank X is re-requested by the writer, s_ready stays 0 that cycle. Bank X becomes writable on the next cycle.
- Blocks are emitted in arrival order; no block is reordered or dropped.
- flush:
  - On the next edge, both banks become EMPTY and all pointers return to 0.
  - flush overrides any write or read handshake in the same cycle; that byte is discarded and not counted.
  - Bank data contents need not be cleared.
- Reset (rst_n low, asynchronous): same state as flush takes effect immediately. Output reset values: s_ready = 1, m_valid = 0, m_last = 0, m_data = 0x00.

## Timing
- Latency: the 16th input byte is accepted at edge N. m_valid = 1 from edge N (cycle N+1), with the first output byte available.
- Throughput: one byte per cycle sustained in both directions with s_valid and m_ready held high. Input is never stalled after the first block: B1 fills while B0 drains.
- With m_ready held 0: s_ready drops after 32 bytes have been accepted (both banks FULL).
- m_data, m_valid and m_last are stable while m_valid && !m_ready.
- On rst_n deassertion, s_ready = 1 with no extra wait cycle.

## Test plan
- Single block, input bytes 0x00..0x0F, m_ready = 1 → output 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03. m_last on 0x03. First m_valid one cycle after input byte 0x0F is accepted.
- FIPS-197 inverse-cipher round state 0x7a9f102789d5f50b2beffd9f3dca4ce7 → output equal to InvShiftRows of that state computed by the bench model.
- Back-to-back: 4 blocks with s_valid = 1 and m_ready = 1 continuously → 64 output bytes with no bubble after the first 16-cycle fill. s_ready never drops.
- Backpressure: m_ready = 0 → s_ready falls after exactly 32 bytes accepted. Then random m_ready → both blocks are emitted in order and intact.
- flush asserted mid-fill (after 7 bytes) and mid-drain (after 5 output bytes) → next cycle m_valid = 0 and s_ready = 1. The next block, 0x00..0x0F, produces the exact sequence from the first scenario.
- rst_n pulsed low asynchronously mid-block → outputs reach their reset values without a clock edge. Recovery matches the flush case.
